// File: rtl/mem_stage_if.sv
// EX/MEM/WB/ID bus bundle for the MEM stage: EX-side inputs, stall vector, SRAM read data, and MEM outputs.
// The master side drives EX, stall and SRAM signals; the slave side (mem_stage) drives the result buses.
interface mem_stage_if #(
    parameter int EX_TO_MEM_WD = 146,
    parameter int MEM_TO_WB_WD = 136,
    parameter int MEM_TO_ID_WD = 104,
    parameter int STALL_W      = 6
);
    logic [STALL_W-1:0]      stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;
    logic                    mem_addr_err;

    modport master (
        output stall, ex_to_mem_bus, data_sram_rdata,
        input  mem_to_wb_bus, mem_to_id_bus, mem_addr_err
    );

    modport slave (
        input  stall, ex_to_mem_bus, data_sram_rdata,
        output mem_to_wb_bus, mem_to_id_bus, mem_addr_err
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: registers the EX->MEM bus (1 cycle), picks ALU result or extended load data for write-back.
// Stall[3] holds MEM, stall[3]&!stall[4] injects a bubble; SRAM read data is buffered while WB stalls.
module mem_stage (
    input  logic         clk,
    input  logic         rst,
    mem_stage_if.slave   mem_if
);
    typedef struct packed {
        logic [3:0]  readen;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;

    localparam logic [3:0] RD_LW  = 4'b1111;
    localparam logic [3:0] RD_LB  = 4'b0001;
    localparam logic [3:0] RD_LBU = 4'b0010;
    localparam logic [3:0] RD_LH  = 4'b0011;
    localparam logic [3:0] RD_LHU = 4'b0100;

    ex_mem_t     r_bus;
    logic        r_hold_valid;
    logic [31:0] r_hold_data;

    logic        w_is_load;
    logic [1:0]  w_addr;
    logic [31:0] w_load_src;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_rf_wdata;
    logic        w_addr_err;
    logic        w_unused;

    assign w_unused = &{1'b0, mem_if.stall[5], mem_if.stall[2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus <= '0;
        end else if (mem_if.stall[3] && !mem_if.stall[4]) begin
            r_bus <= '0;
        end else if (!mem_if.stall[3]) begin
            r_bus <= ex_mem_t'(mem_if.ex_to_mem_bus);
        end
    end

    // Any cycle WB advances, the buffered word has been consumed (this includes bubble cycles).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (!mem_if.stall[4]) begin
            r_hold_valid <= 1'b0;
        end else if (w_is_load && !r_hold_valid) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= mem_if.data_sram_rdata;
        end
    end

    always_comb begin
        w_is_load = r_bus.ram_en && (r_bus.ram_wen == 4'b0000) &&
                    (r_bus.readen inside {RD_LW, RD_LB, RD_LBU, RD_LH, RD_LHU});
        w_addr     = r_bus.ex_result[1:0];
        w_load_src = r_hold_valid ? r_hold_data : mem_if.data_sram_rdata;

        w_byte = w_load_src[7:0];
        case (w_addr)
            2'd1:    w_byte = w_load_src[15:8];
            2'd2:    w_byte = w_load_src[23:16];
            2'd3:    w_byte = w_load_src[31:24];
            default: w_byte = w_load_src[7:0];
        endcase
        w_half = w_addr[1] ? w_load_src[31:16] : w_load_src[15:0];

        w_load_data = w_load_src;
        case (r_bus.readen)
            RD_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            RD_LBU:  w_load_data = {24'h0, w_byte};
            RD_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            RD_LHU:  w_load_data = {16'h0, w_half};
            default: w_load_data = w_load_src;
        endcase

        w_rf_wdata = r_bus.sel_rf_res ? w_load_data : r_bus.ex_result;

        w_addr_err = 1'b0;
        if (w_is_load) begin
            if (r_bus.readen == RD_LW)
                w_addr_err = (w_addr != 2'b00);
            else if (r_bus.readen == RD_LH || r_bus.readen == RD_LHU)
                w_addr_err = w_addr[0];
        end
    end

    assign mem_if.mem_to_wb_bus = {r_bus.hi_we, r_bus.lo_we, r_bus.hi, r_bus.lo, r_bus.pc,
                                   r_bus.rf_we, r_bus.rf_waddr, w_rf_wdata};
    assign mem_if.mem_to_id_bus = {r_bus.hi_we, r_bus.lo_we, r_bus.hi, r_bus.lo,
                                   r_bus.rf_we, r_bus.rf_waddr, w_rf_wdata};
    assign mem_if.mem_addr_err  = w_addr_err;
endmodule

// File: tb/tb_mem_stage.sv
// Directed vector bench for mem_stage: load extension table, bubbles, hold buffer and reset mid-stall.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mem_stage_if bus_if ();

    mem_stage dut (
        .clk    (clk),
        .rst    (rst),
        .mem_if (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  readen;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel;
        logic [31:0] res;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
        logic        exp_err;
    } vec_t;

    vec_t vec [14];

    task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [145:0] mk_bus(input logic [3:0] readen, input int i,
                                            input logic ram_en, input logic [3:0] ram_wen,
                                            input logic sel, input logic [31:0] res);
        logic [31:0] hi = 32'h1111_0000 + i;
        logic [31:0] pc = 32'hBFC0_0000 + 4 * i;
        logic [4:0]  wa = 5'(i + 1);
        return {readen, i[0], i[1], hi, ~hi, pc, ram_en, ram_wen, sel, 1'b1, wa, res};
    endfunction

    function automatic logic [135:0] exp_wb(input int i, input logic [31:0] wdata);
        logic [31:0] hi = 32'h1111_0000 + i;
        logic [31:0] pc = 32'hBFC0_0000 + 4 * i;
        logic [4:0]  wa = 5'(i + 1);
        return {i[0], i[1], hi, ~hi, pc, 1'b1, wa, wdata};
    endfunction

    function automatic logic [103:0] exp_id(input int i, input logic [31:0] wdata);
        logic [31:0] hi = 32'h1111_0000 + i;
        logic [4:0]  wa = 5'(i + 1);
        return {i[0], i[1], hi, ~hi, 1'b1, wa, wdata};
    endfunction

    task automatic drive(input logic [5:0] st, input logic [145:0] b, input logic [31:0] rd);
        bus_if.stall           = st;
        bus_if.ex_to_mem_bus   = b;
        bus_if.data_sram_rdata = rd;
    endtask

    initial begin
        vec[0]  = '{4'b0001, 1'b1, 4'b0000, 1'b1, 32'h1002, 32'h80FF1234, 32'hFFFFFFFF, 1'b0}; // lb
        vec[1]  = '{4'b0010, 1'b1, 4'b0000, 1'b1, 32'h1002, 32'h80FF1234, 32'h000000FF, 1'b0}; // lbu
        vec[2]  = '{4'b0001, 1'b1, 4'b0000, 1'b1, 32'h1001, 32'h80FF1234, 32'h00000012, 1'b0};
        vec[3]  = '{4'b0001, 1'b1, 4'b0000, 1'b1, 32'h1003, 32'h80FF1234, 32'hFFFFFF80, 1'b0};
        vec[4]  = '{4'b0010, 1'b1, 4'b0000, 1'b1, 32'h1000, 32'h80FF1234, 32'h00000034, 1'b0};
        vec[5]  = '{4'b0011, 1'b1, 4'b0000, 1'b1, 32'h1002, 32'h80FF1234, 32'hFFFF80FF, 1'b0}; // lh
        vec[6]  = '{4'b0100, 1'b1, 4'b0000, 1'b1, 32'h1002, 32'h80FF1234, 32'h000080FF, 1'b0}; // lhu
        vec[7]  = '{4'b0011, 1'b1, 4'b0000, 1'b1, 32'h1001, 32'h80FF1234, 32'h00001234, 1'b1};
        vec[8]  = '{4'b0100, 1'b1, 4'b0000, 1'b1, 32'h1003, 32'h80FF1234, 32'h000080FF, 1'b1};
        vec[9]  = '{4'b0011, 1'b1, 4'b0000, 1'b1, 32'h1000, 32'h80FF1234, 32'h00001234, 1'b0};
        vec[10] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 32'h1000, 32'h80FF1234, 32'h80FF1234, 1'b0}; // lw
        vec[11] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 32'h1002, 32'h80FF1234, 32'h80FF1234, 1'b1};
        vec[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'h12345678, 32'h80FF1234, 32'h12345678, 1'b0}; // alu
        vec[13] = '{4'b0101, 1'b1, 4'b0001, 1'b0, 32'h1003, 32'h80FF1234, 32'h00001003, 1'b0}; // sb

        // Reset with a live bus and no stall: outputs must still read zero.
        drive(6'b000000, mk_bus(4'b1111, 3, 1'b1, 4'b0000, 1'b1, 32'h1001), 32'hCAFEF00D);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_wb", bus_if.mem_to_wb_bus, '0);
        chk("reset_id", {32'h0, bus_if.mem_to_id_bus}, '0);
        chk("reset_err", {135'h0, bus_if.mem_addr_err}, '0);
        chk("reset_hold", {135'h0, dut.r_hold_valid}, '0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(6'b000000, mk_bus(vec[i].readen, i, vec[i].ram_en, vec[i].ram_wen,
                                    vec[i].sel, vec[i].res), vec[i].rdata);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_wb", i), bus_if.mem_to_wb_bus, exp_wb(i, vec[i].exp_wdata));
            chk($sformatf("vec%0d_id", i), {32'h0, bus_if.mem_to_id_bus},
                {32'h0, exp_id(i, vec[i].exp_wdata)});
            chk($sformatf("vec%0d_err", i), {135'h0, bus_if.mem_addr_err}, {135'h0, vec[i].exp_err});
        end

        // Bubble: MEM stalled while WB advances clears the pipeline register.
        drive(6'b001111, mk_bus(4'b0000, 20, 1'b0, 4'b0000, 1'b0, 32'h55AA55AA), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("bubble_wb", bus_if.mem_to_wb_bus, '0);
        chk("bubble_id", {32'h0, bus_if.mem_to_id_bus}, '0);

        // Both MEM and WB stalled: the register holds.
        drive(6'b000000, mk_bus(4'b0000, 21, 1'b0, 4'b0000, 1'b0, 32'h0BADF00D), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("pre_hold_wb", bus_if.mem_to_wb_bus, exp_wb(21, 32'h0BADF00D));
        drive(6'b011111, mk_bus(4'b0000, 22, 1'b0, 4'b0000, 1'b0, 32'h77777777), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("stall_hold_wb", bus_if.mem_to_wb_bus, exp_wb(21, 32'h0BADF00D));

        // Read-data hold: lw in MEM while WB stalls, SRAM data changes underneath.
        drive(6'b000000, mk_bus(4'b1111, 5, 1'b1, 4'b0000, 1'b1, 32'h2000), 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        chk("hold_c0", bus_if.mem_to_wb_bus, exp_wb(5, 32'hDEADBEEF));
        bus_if.stall = 6'b011111;
        @(posedge clk);
        @(negedge clk);
        bus_if.data_sram_rdata = 32'h0;
        #1;
        chk("hold_c1", bus_if.mem_to_wb_bus, exp_wb(5, 32'hDEADBEEF));
        chk("hold_valid_set", {135'h0, dut.r_hold_valid}, {135'h0, 1'b1});
        @(posedge clk);
        @(negedge clk);
        bus_if.data_sram_rdata = 32'h1;
        #1;
        chk("hold_c2", bus_if.mem_to_wb_bus, exp_wb(5, 32'hDEADBEEF));
        drive(6'b000000, mk_bus(4'b0000, 6, 1'b0, 4'b0000, 1'b0, 32'h00C0FFEE), 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("hold_release", {135'h0, dut.r_hold_valid}, '0);
        chk("after_release_wb", bus_if.mem_to_wb_bus, exp_wb(6, 32'h00C0FFEE));

        // Reset in the middle of a held load discards it and empties the buffer.
        drive(6'b000000, mk_bus(4'b1111, 7, 1'b1, 4'b0000, 1'b1, 32'h3000), 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        bus_if.stall = 6'b011111;
        @(posedge clk);
        @(negedge clk);
        bus_if.data_sram_rdata = 32'h0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_stall_wb", bus_if.mem_to_wb_bus, '0);
        chk("rst_stall_id", {32'h0, bus_if.mem_to_id_bus}, '0);
        chk("rst_stall_err", {135'h0, bus_if.mem_addr_err}, '0);
        chk("rst_stall_hold", {135'h0, dut.r_hold_valid}, '0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
